// File: rtl/bus_responder_if.sv
// Strobe/ready memory bus between the CPU and a bus_responder.
// BUS_RESPONDER_ERR_EN adds the o_bus_err signal.
interface bus_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_bus_clk;
  logic              i_bus_we;
  logic [ADDR_W-1:0] i_bus_addr;
  logic [DATA_W-1:0] i_bus_data;
  logic [DATA_W-1:0] o_bus_data;
  logic              o_bus_data_ready;
  logic              o_busy;
`ifdef BUS_RESPONDER_ERR_EN
  logic              o_bus_err;
`endif

  modport slave (
    input  i_bus_clk,
    input  i_bus_we,
    input  i_bus_addr,
    input  i_bus_data,
    output o_bus_data,
    output o_bus_data_ready,
    output o_busy
`ifdef BUS_RESPONDER_ERR_EN
    , output o_bus_err
`endif
  );

  modport master (
    output i_bus_clk,
    output i_bus_we,
    output i_bus_addr,
    output i_bus_data,
    input  o_bus_data,
    input  o_bus_data_ready,
    input  o_busy
`ifdef BUS_RESPONDER_ERR_EN
    , input o_bus_err
`endif
  );
endinterface

// File: rtl/bus_responder.sv
// Word-addressed RAM window on the CPU strobe/ready bus.
// BUS_RESPONDER_ERR_EN flags out-of-window accesses on o_bus_err.
module bus_responder #(
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter int                 DEPTH_LOG2  = 12,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int                 WAIT_STATES = 0,
  parameter logic [DATA_W-1:0]  FILL_DATA   = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  bus_responder_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RDATA,
    S_HOLD
  } state_t;

  state_t                r_state;
  logic                  r_strobe_q;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_inwin;
  logic [DATA_W-1:0]     r_data;
  logic                  r_ready;
  logic                  r_busy;
  logic [DATA_W-1:0]     r_mem [DEPTH];
`ifdef BUS_RESPONDER_ERR_EN
  logic                  r_err;
`endif

  logic                  w_start;
  logic [ADDR_W-1:0]     w_off;
  logic                  w_inwin;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_wr;

  assign w_start = bus.i_bus_clk & ~r_strobe_q;
  assign w_off   = bus.i_bus_addr - BASE_ADDR;
  assign w_inwin = (w_off >> DEPTH_LOG2) == '0;
  assign w_idx   = w_off[DEPTH_LOG2-1:0];
  assign w_wr    = w_start & bus.i_bus_we & w_inwin
                 & (r_state == S_IDLE);

  // RAM contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[w_idx] <= bus.i_bus_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_strobe_q <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_inwin    <= 1'b0;
      r_data     <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
`ifdef BUS_RESPONDER_ERR_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_strobe_q <= bus.i_bus_clk;
      unique case (r_state)
        S_IDLE: begin
`ifdef BUS_RESPONDER_ERR_EN
          r_err <= w_start & bus.i_bus_we & ~w_inwin;
`endif
          if (w_start && !bus.i_bus_we) begin
            r_idx   <= w_idx;
            r_inwin <= w_inwin;
            r_busy  <= 1'b1;
            if (WAIT_STATES == 0) begin
              r_state <= S_RDATA;
            end else begin
              r_cnt   <= 4'(WAIT_STATES);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.i_bus_clk) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_state <= S_RDATA;
          end
        end
        S_RDATA: begin
          r_data  <= r_inwin ? r_mem[r_idx] : FILL_DATA;
          r_ready <= 1'b1;
`ifdef BUS_RESPONDER_ERR_EN
          r_err   <= ~r_inwin;
`endif
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (!bus.i_bus_clk) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
`ifdef BUS_RESPONDER_ERR_EN
            r_err   <= 1'b0;
`endif
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_bus_data       = r_data;
  assign bus.o_bus_data_ready = r_ready;
  assign bus.o_busy           = r_busy;
`ifdef BUS_RESPONDER_ERR_EN
  assign bus.o_bus_err        = r_err;
`endif
endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: zero and three wait-state instances
// driven with directed and random traffic against a RAM model.
module tb_bus_responder;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          DL   = 4;
  localparam int          NW   = 16;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] FILL = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       bclk = '0;
  logic [1:0]       bwe = '0;
  logic [1:0][31:0] baddr = '0;
  logic [1:0][31:0] bwdat = '0;
  wire  [1:0][31:0] rdat;
  wire  [1:0]       rdy;
  wire  [1:0]       busy;
`ifdef BUS_RESPONDER_ERR_EN
  wire  [1:0]       err;
`endif

  bus_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bif0 ();
  bus_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bif1 ();

  assign bif0.i_bus_clk  = bclk[0];
  assign bif0.i_bus_we   = bwe[0];
  assign bif0.i_bus_addr = baddr[0];
  assign bif0.i_bus_data = bwdat[0];
  assign bif1.i_bus_clk  = bclk[1];
  assign bif1.i_bus_we   = bwe[1];
  assign bif1.i_bus_addr = baddr[1];
  assign bif1.i_bus_data = bwdat[1];
  assign rdat[0] = bif0.o_bus_data;
  assign rdat[1] = bif1.o_bus_data;
  assign rdy[0]  = bif0.o_bus_data_ready;
  assign rdy[1]  = bif1.o_bus_data_ready;
  assign busy[0] = bif0.o_busy;
  assign busy[1] = bif1.o_busy;
`ifdef BUS_RESPONDER_ERR_EN
  assign err[0]  = bif0.o_bus_err;
  assign err[1]  = bif1.o_bus_err;
`endif

  bus_responder #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL),
    .BASE_ADDR(BASE), .WAIT_STATES(0), .FILL_DATA(FILL)
  ) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bif0));

  bus_responder #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL),
    .BASE_ADDR(BASE), .WAIT_STATES(3), .FILL_DATA(FILL)
  ) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bif1));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [2][NW];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < NW;
  endfunction

  function automatic logic [31:0] ref_rd(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return in_win(a) ? ref_mem[d][off[3:0]] : FILL;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int d, input logic [31:0] a,
                          input logic [31:0] v);
    logic [31:0] off;
    off = a - BASE;
    step();
    bclk[d] = 1'b1;
    bwe[d] = 1'b1;
    baddr[d] = a;
    bwdat[d] = v;
    step();
    bclk[d] = 1'b0;
    bwe[d] = 1'b0;
    if (in_win(a)) ref_mem[d][off[3:0]] = v;
    n_cmp++;
    if (busy[d] !== 1'b0 || rdy[d] !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_idle d%0d busy=%b rdy=%b want 0/0",
               d, busy[d], rdy[d]);
    end
`ifdef BUS_RESPONDER_ERR_EN
    n_cmp++;
    if (err[d] !== !in_win(a)) begin
      n_bad++;
      $display("FAIL wr_err d%0d got %b want %b", d, err[d], !in_win(a));
    end
`endif
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input int hold);
    logic [31:0] exp;
    int lat;
    exp = ref_rd(d, a);
    lat = 0;
    step();
    bclk[d] = 1'b1;
    bwe[d] = 1'b0;
    baddr[d] = a;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      step();
      if (rdy[d] === 1'b1) begin
        lat = c;
      end else begin
        n_cmp++;
        if (busy[d] !== 1'b1) begin
          n_bad++;
          $display("FAIL rd_busy d%0d cyc %0d got %b want 1", d, c, busy[d]);
        end
      end
    end
    n_cmp++;
    if (lat != 2 + ws_of(d)) begin
      n_bad++;
      $display("FAIL rd_lat d%0d got %0d want %0d", d, lat, 2 + ws_of(d));
    end
    n_cmp++;
    if (rdat[d] !== exp || busy[d] !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_data d%0d a=%h got %h/%b want %h/1",
               d, a, rdat[d], busy[d], exp);
    end
`ifdef BUS_RESPONDER_ERR_EN
    n_cmp++;
    if (err[d] !== !in_win(a)) begin
      n_bad++;
      $display("FAIL rd_err d%0d got %b want %b", d, err[d], !in_win(a));
    end
`endif
    for (int h = 0; h < hold; h++) begin
      step();
      n_cmp++;
      if (rdy[d] !== 1'b1 || rdat[d] !== exp || busy[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL rd_hold d%0d h%0d rdy=%b data=%h want 1/%h",
                 d, h, rdy[d], rdat[d], exp);
      end
    end
    bclk[d] = 1'b0;
    step();
    n_cmp++;
    if (rdy[d] !== 1'b0 || busy[d] !== 1'b0 || rdat[d] !== exp) begin
      n_bad++;
      $display("FAIL rd_release d%0d rdy=%b busy=%b data=%h want 0/0/%h",
               d, rdy[d], busy[d], rdat[d], exp);
    end
`ifdef BUS_RESPONDER_ERR_EN
    n_cmp++;
    if (err[d] !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_err_clr d%0d got %b want 0", d, err[d]);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rdat[d] !== '0 || rdy[d] !== 1'b0 || busy[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset d%0d data=%h rdy=%b busy=%b want 0/0/0",
                 d, rdat[d], rdy[d], busy[d]);
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NW; i++)
        do_write(d, BASE + 32'(i), $urandom);
  endtask

  task automatic test_ws0();
    do_write(0, BASE + 32'd5, 32'hDEAD_BEEF);
    do_write(1, BASE + 32'd5, 32'hDEAD_BEEF);
    do_read(0, BASE + 32'd5, 0);
    do_write(0, BASE + 32'd9, 32'h1234_5678);
    do_read(0, BASE + 32'd9, 2);
  endtask

  task automatic test_ws3();
    do_read(1, BASE + 32'd5, 0);
    do_read(1, BASE + 32'd15, 1);
  endtask

  task automatic test_oow();
    for (int d = 0; d < 2; d++) begin
      do_read(d, BASE + 32'(NW), 0);
      do_read(d, BASE - 32'd1, 1);
      do_write(d, BASE + 32'(NW), $urandom);
      do_read(d, BASE, 0);
    end
  endtask

  task automatic test_abort();
    int seen;
    step();
    bclk[1] = 1'b1;
    bwe[1] = 1'b0;
    baddr[1] = BASE + 32'd3;
    step();
    step();
    bclk[1] = 1'b0;
    step();
    n_cmp++;
    if (busy[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle got busy=%b want 0", busy[1]);
    end
    seen = 0;
    repeat (8) begin
      step();
      if (rdy[1] !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL abort_rdy got %0d ready cycles want 0", seen);
    end
    do_read(1, BASE + 32'd3, 0);
  endtask

  task automatic test_hold();
    int seen;
    do_read(0, BASE + 32'd7, 10);
    seen = 0;
    repeat (6) begin
      step();
      if (rdy[0] !== 1'b0 || busy[0] !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL hold_retrig got %0d active cycles want 0", seen);
    end
    do_read(1, BASE + 32'd7, 10);
  endtask

  task automatic test_reset_mid();
    int seen;
    step();
    bclk[1] = 1'b1;
    bwe[1] = 1'b0;
    baddr[1] = BASE + 32'd5;
    step();
    step();
    rst_n = 1'b0;
    bclk[1] = 1'b0;
    #1;
    n_cmp++;
    if (busy[1] !== 1'b0 || rdy[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid busy=%b rdy=%b want 0/0", busy[1], rdy[1]);
    end
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      step();
      if (rdy[1] !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rst_mid_rdy got %0d ready cycles want 0", seen);
    end
    do_read(1, BASE + 32'd5, 0);
    do_read(0, BASE + 32'd5, 0);
  endtask

  task automatic test_random();
    int d;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      d = int'($urandom_range(1, 0));
      if ($urandom_range(4, 0) == 0)
        a = BASE + 32'(NW) + 32'($urandom_range(7, 0));
      else
        a = BASE + 32'($urandom_range(NW - 1, 0));
      if ($urandom_range(1, 0) == 1)
        do_write(d, a, $urandom);
      else
        do_read(d, a, int'($urandom_range(2, 0)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_ws0();
    test_ws3();
    test_oow();
    test_abort();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
